// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_bank
//  Description : APB3 register bank with RW control words, RO status words,
//                programmable wait states, PSLVERR on bad accesses and
//                per-word write pulses. Optional interrupt pending/mask
//                registers are enabled by defining APB_REG_BANK_IRQ_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_reg_bank #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CTRL    = 4,
    parameter int NUM_STAT    = 4,
    parameter int WAIT_STATES = 0,
    parameter int NUM_IRQ     = 8
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] ext_status,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ext_control,
    output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
    input  logic [NUM_IRQ-1:0]             irq_src,
    output logic                           irq_o
);

    localparam logic [ADDR_WIDTH-1:0] c_CTRL_END = ADDR_WIDTH'(NUM_CTRL);
    localparam logic [ADDR_WIDTH-1:0] c_MAP_END  = ADDR_WIDTH'(NUM_CTRL + NUM_STAT);
    localparam logic [3:0]            c_WAIT     = 4'(WAIT_STATES);

    logic                           w_access;
    logic                           w_ready;
    logic                           w_is_ctrl;
    logic                           w_is_stat;
    logic                           w_valid;
    logic                           w_err;
    logic                           w_commit;
    logic [3:0]                     r_cnt;
    logic [NUM_CTRL*DATA_WIDTH-1:0] r_ctrl;
    logic [NUM_CTRL-1:0]            r_pulse;
    logic [DATA_WIDTH-1:0]          w_rdata;

    assign w_access  = PSEL && PENABLE;
    assign w_ready   = w_access && (r_cnt == c_WAIT);
    assign w_is_ctrl = (PADDR < c_CTRL_END);
    assign w_is_stat = !w_is_ctrl && (PADDR < c_MAP_END);

`ifdef APB_REG_BANK_IRQ_EN
    localparam logic [ADDR_WIDTH-1:0] c_PEND_IDX = ADDR_WIDTH'(NUM_CTRL + NUM_STAT);
    localparam logic [ADDR_WIDTH-1:0] c_MASK_IDX = ADDR_WIDTH'(NUM_CTRL + NUM_STAT + 1);

    logic               w_is_pend;
    logic               w_is_mask;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_irq;

    assign w_is_pend = (PADDR == c_PEND_IDX);
    assign w_is_mask = (PADDR == c_MASK_IDX);
    assign w_valid   = w_is_ctrl || w_is_stat || w_is_pend || w_is_mask;
    assign w_rise    = irq_src & ~r_irq_prev;
    assign w_clr     = (w_commit && w_is_pend) ? PWDATA[NUM_IRQ-1:0] : '0;

    // New edges are OR-ed in after the W1C clear so a coincident set wins.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_irq_prev <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_prev <= irq_src;
            r_pend     <= (r_pend & ~w_clr) | w_rise;
            if (w_commit && w_is_mask) begin
                r_mask <= PWDATA[NUM_IRQ-1:0];
            end
            r_irq      <= |(r_pend & r_mask);
        end
    end

    assign irq_o = r_irq;
`else
    logic w_unused_irq;

    assign w_valid      = w_is_ctrl || w_is_stat;
    assign w_unused_irq = ^irq_src;
    assign irq_o        = 1'b0;
`endif

    assign w_err    = !w_valid || (PWRITE && w_is_stat);
    assign w_commit = w_ready && PWRITE && !w_err;

    // Counter restarts whenever the access phase ends, completed or abandoned.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cnt <= 4'd0;
        end else if (w_access && !w_ready) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_ctrl  <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= '0;
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (w_commit && (PADDR == ADDR_WIDTH'(k))) begin
                    r_ctrl[k*DATA_WIDTH +: DATA_WIDTH] <= PWDATA;
                    r_pulse[k]                         <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ready && !PWRITE && !w_err) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (PADDR == ADDR_WIDTH'(k)) begin
                    w_rdata = r_ctrl[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int k = 0; k < NUM_STAT; k++) begin
                if (PADDR == ADDR_WIDTH'(NUM_CTRL + k)) begin
                    w_rdata = ext_status[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`ifdef APB_REG_BANK_IRQ_EN
            if (w_is_pend) begin
                w_rdata = DATA_WIDTH'(r_pend);
            end
            if (w_is_mask) begin
                w_rdata = DATA_WIDTH'(r_mask);
            end
`endif
        end
    end

    assign PRDATA        = w_rdata;
    assign PREADY        = w_ready;
    assign PSLVERR       = w_ready && w_err;
    assign ext_control   = r_ctrl;
    assign ctrl_wr_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_reg_bank
//  Description : Randomized self-checking bench for apb_reg_bank against a
//                word-level register-map model (WAIT_STATES = 3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_reg_bank;

    localparam int c_WS = 3;
`ifdef APB_REG_BANK_IRQ_EN
    localparam int c_MAP_END = 10;
`else
    localparam int c_MAP_END = 8;
`endif

    logic         PCLK;
    logic         PRESET;
    logic         PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [7:0]   PADDR;
    logic [31:0]  PWDATA;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;
    logic [127:0] ext_status;
    logic [127:0] ext_control;
    logic [3:0]   ctrl_wr_pulse;
    logic [7:0]   irq_src;
    logic         irq_o;

    logic [31:0]  st     [4];
    logic [31:0]  m_ctrl [4];
    logic [7:0]   m_pend;
    logic [7:0]   m_mask;
    int           n_tests;
    int           n_fail;

    assign ext_status = {st[3], st[2], st[1], st[0]};

    apb_reg_bank #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_CTRL   (4),
        .NUM_STAT   (4),
        .WAIT_STATES(c_WS),
        .NUM_IRQ    (8)
    ) u_dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .ext_status   (ext_status),
        .ext_control  (ext_control),
        .ctrl_wr_pulse(ctrl_wr_pulse),
        .irq_src      (irq_src),
        .irq_o        (irq_o)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic wr, input logic [7:0] a);
        return (int'(a) >= c_MAP_END) || (wr && a >= 8'd4 && a < 8'd8);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        if (a < 8'd4) return m_ctrl[a[1:0]];
        if (a < 8'd8) return st[a[1:0]];
`ifdef APB_REG_BANK_IRQ_EN
        if (a == 8'd8) return {24'h0, m_pend};
        if (a == 8'd9) return {24'h0, m_mask};
`endif
        return 32'h0;
    endfunction

    function automatic logic model_irq();
`ifdef APB_REG_BANK_IRQ_EN
        return |(m_pend & m_mask);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_ctrl_words(input string tag);
        for (int k = 0; k < 4; k++) begin
            check(tag, {32'h0, ext_control[k*32 +: 32]}, {32'h0, m_ctrl[k]});
        end
    endtask

    // One complete APB transfer; raise is OR-ed into irq_src during the PREADY cycle.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [7:0] raise);
        int          waits;
        logic        got_ready;
        logic [31:0] rd;
        logic        err;
        logic        e_err;
        logic [31:0] e_rd;
        logic [3:0]  e_pulse;
        waits     = 0;
        got_ready = 1'b0;
        rd        = '0;
        err       = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        while (!got_ready && waits < 40) begin
            @(negedge PCLK);
            if (PREADY) begin
                got_ready = 1'b1;
                rd        = PRDATA;
                err       = PSLVERR;
                irq_src   = irq_src | raise;
            end else begin
                waits++;
            end
        end
        check("ready_seen", {63'h0, got_ready}, 64'h1);
        check("wait_cycles", 64'(waits), 64'(c_WS));
        e_err   = model_err(wr, a);
        e_rd    = (wr || e_err) ? 32'h0 : model_read(a);
        e_pulse = '0;
        check("pslverr", {63'h0, err}, {63'h0, e_err});
        check("prdata", {32'h0, rd}, {32'h0, e_rd});
        if (wr && !e_err) begin
            if (a < 8'd4) begin
                m_ctrl[a[1:0]] = wd;
                e_pulse        = 4'b0001 << a[1:0];
            end
`ifdef APB_REG_BANK_IRQ_EN
            if (a == 8'd8) m_pend = m_pend & ~wd[7:0];
            if (a == 8'd9) m_mask = wd[7:0];
`endif
        end
`ifdef APB_REG_BANK_IRQ_EN
        m_pend = m_pend | raise;
`endif
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("wr_pulse", {60'h0, ctrl_wr_pulse}, {60'h0, e_pulse});
        check_ctrl_words("ctrl_word");
        @(negedge PCLK);
        check("wr_pulse_end", {60'h0, ctrl_wr_pulse}, 64'h0);
        check("irq_o", {63'h0, irq_o}, {63'h0, model_irq()});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        PCLK    = 1'b0;
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        irq_src = '0;
        m_pend  = '0;
        m_mask  = '0;
        for (int k = 0; k < 4; k++) begin
            st[k]     = '0;
            m_ctrl[k] = '0;
        end
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_ctrl", {63'h0, |ext_control}, 64'h0);
        check("rst_pulse", {60'h0, ctrl_wr_pulse}, 64'h0);
        check("rst_irq", {63'h0, irq_o}, 64'h0);
        check("rst_ready", {63'h0, PREADY}, 64'h0);

        // Directed: write/read back, status read, error accesses.
        xfer(1'b1, 8'd2, 32'hDEADBEEF, 8'h0);
        xfer(1'b0, 8'd2, 32'h0, 8'h0);
        st[1] = 32'h0000_1234;
        xfer(1'b0, 8'd5, 32'h0, 8'h0);
        xfer(1'b1, 8'd6, 32'hFFFF_FFFF, 8'h0);
        xfer(1'b0, 8'd12, 32'h0, 8'h0);
        xfer(1'b1, 8'd2, 32'h1111_2222, 8'h0);
        xfer(1'b1, 8'd2, 32'h3333_4444, 8'h0);

        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 4; k++) st[k] = $urandom;
            xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 13)), $urandom, 8'h0);
        end

        // Reset during the second wait cycle of a write to word 0.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd0; PWDATA = 32'hCAFE_F00D;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
        for (int k = 0; k < 4; k++) m_ctrl[k] = '0;
        m_pend = '0;
        m_mask = '0;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
        @(negedge PCLK);
        check_ctrl_words("abort_ctrl");
        check("abort_pulse", {60'h0, ctrl_wr_pulse}, 64'h0);
        @(negedge PCLK);
        check("abort_pulse2", {60'h0, ctrl_wr_pulse}, 64'h0);
        xfer(1'b1, 8'd0, 32'hA5A5_5A5A, 8'h0);

`ifdef APB_REG_BANK_IRQ_EN
        xfer(1'b1, 8'd9, 32'h0000_0001, 8'h0);
        @(posedge PCLK); #1;
        irq_src[0] = 1'b1;
        m_pend     = m_pend | 8'h01;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("irq_assert", {63'h0, irq_o}, 64'h1);
        xfer(1'b0, 8'd8, 32'h0, 8'h0);
        xfer(1'b1, 8'd8, 32'h0000_0001, 8'h0);
        xfer(1'b1, 8'd8, 32'h0000_0008, 8'h08);
        xfer(1'b0, 8'd8, 32'h0, 8'h0);
        xfer(1'b0, 8'd9, 32'h0, 8'h0);
`else
        irq_src = 8'hFF;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("irq_tied", {63'h0, irq_o}, 64'h0);
        xfer(1'b0, 8'd8, 32'h0, 8'h0);
        xfer(1'b1, 8'd9, 32'h0000_00FF, 8'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
